sobel_frame_ctrl: RTL and testbench

//   Frame sequencer/configurator for the 3x3 sobel convolution core. Forwards a raster pixel stream

---
 rtl/sobel_pkg.sv | 38 +++
 rtl/sobel_frame_ctrl_counter.sv | 59 +++++
 rtl/sobel_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and kernel weight tables for the sobel frame sequencer.
// Weights are ordered [0]=top-left (oldest pixel) .. [8]=bottom-right (newest pixel).
package sobel_pkg;

    typedef enum logic [1:0] {
        KERNEL_GX       = 2'd0,
        KERNEL_GY       = 2'd1,
        KERNEL_LAPLACE  = 2'd2,
        KERNEL_IDENTITY = 2'd3
    } kernel_sel_e;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_DRAIN = 2'd2
    } ctrl_state_e;

    typedef logic [0:8][2:0] weights_t;

    // Each weight is a signed 3-bit two's complement value.
    localparam weights_t GX_W  = {3'h7, 3'h0, 3'h1, 3'h6, 3'h0, 3'h2, 3'h7, 3'h0, 3'h1};
    localparam weights_t GY_W  = {3'h7, 3'h6, 3'h7, 3'h0, 3'h0, 3'h0, 3'h1, 3'h2, 3'h1};
    localparam weights_t LAP_W = {3'h0, 3'h1, 3'h0, 3'h1, 3'h4, 3'h1, 3'h0, 3'h1, 3'h0};
    localparam weights_t ID_W  = {3'h0, 3'h0, 3'h0, 3'h0, 3'h1, 3'h0, 3'h0, 3'h0, 3'h0};

    function automatic weights_t kernel_weights(input kernel_sel_e sel);
        weights_t w;
        case (sel)
            KERNEL_GX:       w = GX_W;
            KERNEL_GY:       w = GY_W;
            KERNEL_LAPLACE:  w = LAP_W;
            KERNEL_IDENTITY: w = ID_W;
            default:         w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sobel_frame_ctrl_counter.sv
// Raster position counter: column wraps into the next row, row wraps at frame end.
module raster_counter #(
    parameter int w_p = 16,
    parameter int h_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   step_i,
    output logic [$clog2(w_p)-1:0] col_o,
    output logic [$clog2(h_p)-1:0] row_o,
    output logic                   last_o
);
    localparam int CW = $clog2(w_p);
    localparam int RW = $clog2(h_p);
    localparam logic [CW-1:0] COL_MAX = CW'(w_p - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(h_p - 1);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // next raster position
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (step_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // position registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 sobel core: gates the input stream per frame, latches the kernel
// configuration at frame start and crops results whose window leaves the frame.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int linewidth_px_p = 16,
    parameter int frame_height_p = 16,
    parameter int width_p        = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [width_p-1:0]   data_i,
    input  logic [1:0]           kernel_sel_i,
    input  logic                 abs_i,
    output logic                 sobel_valid_o,
    input  logic                 sobel_ready_i,
    output logic [width_p-1:0]   sobel_data_o,
    output weights_t             weights_o,
    output logic                 abs_o,
    input  logic                 sobel_valid_i,
    output logic                 sobel_ready_o,
    input  logic [2*width_p-1:0] sobel_data_i,
    input  logic                 sobel_sign_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*width_p-1:0] data_o,
    output logic                 sign_o,
    output logic                 sof_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);
    localparam int CW = $clog2(linewidth_px_p);
    localparam int RW = $clog2(frame_height_p);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);

    localparam logic [1:0] IDLE  = CTRL_IDLE;
    localparam logic [1:0] RUN   = CTRL_RUN;
    localparam logic [1:0] DRAIN = CTRL_DRAIN;

    logic [1:0]    state_q, state_d;
    weights_t      weights_q, weights_d;
    logic          abs_q, abs_d;
    logic          frame_done_q, frame_done_d;
    logic          cfg_load_s;

    logic          accepting_s, in_step_s, out_step_s, keep_s;
    logic [CW-1:0] in_col_s, out_col_s;
    logic [RW-1:0] in_row_s, out_row_s;
    logic          in_last_s, out_last_s, in_origin_s;

    raster_counter #(.w_p(linewidth_px_p), .h_p(frame_height_p)) u_in_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .step_i  (in_step_s),
        .col_o   (in_col_s),
        .row_o   (in_row_s),
        .last_o  (in_last_s)
    );

    raster_counter #(.w_p(linewidth_px_p), .h_p(frame_height_p)) u_out_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .step_i  (out_step_s),
        .col_o   (out_col_s),
        .row_o   (out_row_s),
        .last_o  (out_last_s)
    );

    // Input is held off during DRAIN so the weights never change under old-frame outputs.
    assign accepting_s   = (state_q != DRAIN);
    assign ready_o       = sobel_ready_i & accepting_s;
    assign sobel_valid_o = valid_i & accepting_s;
    assign sobel_data_o  = data_i;
    assign in_step_s     = valid_i & ready_o;
    assign in_origin_s   = (in_col_s == '0) && (in_row_s == '0);

    // Outputs with an incomplete window (line wrap or stale buffer) are silently consumed.
    assign keep_s        = (out_col_s >= COL_TWO) && (out_row_s >= ROW_TWO);
    assign valid_o       = keep_s & sobel_valid_i;
    assign sobel_ready_o = keep_s ? ready_i : 1'b1;
    assign out_step_s    = sobel_valid_i & sobel_ready_o;
    assign data_o        = sobel_data_i;
    assign sign_o        = sobel_sign_i;
    assign sof_o         = keep_s && (out_col_s == COL_TWO) && (out_row_s == ROW_TWO);
    assign last_o        = out_last_s;

    // frame FSM and config latch
    always_comb begin
        state_d    = state_q;
        cfg_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_step_s && in_origin_s) begin
                    state_d    = RUN;
                    cfg_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (in_step_s && in_last_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (out_step_s && out_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_load_s) begin
            weights_d = kernel_weights(kernel_sel_e'(kernel_sel_i));
            abs_d     = abs_i;
        end else begin
            weights_d = weights_q;
            abs_d     = abs_q;
        end

        frame_done_d = (state_q == DRAIN) && out_step_s && out_last_s;
    end

    // state, configuration and done-pulse registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            weights_q    <= '0;
            abs_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            weights_q    <= weights_d;
            abs_q        <= abs_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign weights_o    = weights_q;
    assign abs_o        = abs_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl with a behavioural sobel core behind it (W=H=5, 8-bit pixels).
// Results are predicted from whole-frame 3x3 convolutions over the cropped interior.
module tb_sobel_frame_ctrl;
    import sobel_pkg::*;

    localparam int W = 5;
    localparam int H = 5;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic reset_i;
    logic valid_i, ready_o;
    logic [7:0] data_i;
    logic [1:0] kernel_sel_i;
    logic abs_i;
    logic sobel_valid_o, sobel_ready_i;
    logic [7:0] sobel_data_o;
    weights_t weights_o;
    logic abs_o;
    logic sobel_valid_i, sobel_ready_o;
    logic [15:0] sobel_data_i;
    logic sobel_sign_i;
    logic valid_o, ready_i;
    logic [15:0] data_o;
    logic sign_o, sof_o, last_o, busy_o, frame_done_o;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.linewidth_px_p(W), .frame_height_p(H), .width_p(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .kernel_sel_i(kernel_sel_i), .abs_i(abs_i), .sobel_valid_o(sobel_valid_o),
        .sobel_ready_i(sobel_ready_i), .sobel_data_o(sobel_data_o), .weights_o(weights_o),
        .abs_o(abs_o), .sobel_valid_i(sobel_valid_i), .sobel_ready_o(sobel_ready_o),
        .sobel_data_i(sobel_data_i), .sobel_sign_i(sobel_sign_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .sign_o(sign_o), .sof_o(sof_o), .last_o(last_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    // Behavioural sobel core: one output per accepted pixel, window from raster history.
    logic        sb_vld_q;
    logic [15:0] sb_data_q;
    logic        sb_sign_q;
    logic [7:0]  hist_q [0:2*W+1];

    assign sobel_ready_i = ~sb_vld_q | sobel_ready_o;
    assign sobel_valid_i = sb_vld_q;
    assign sobel_data_i  = sb_data_q;
    assign sobel_sign_i  = sb_sign_q;

    function automatic logic [16:0] sb_result(input logic [7:0] d);
        int s, k, w, px;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                k  = (2 - i) * W + (2 - j);
                px = (k == 0) ? int'(d) : int'(hist_q[k-1]);
                w  = $signed(weights_o[i*3+j]);
                s  = s + w * px;
            end
        end
        if (abs_o && s < 0) return {1'b1, 16'(-s)};
        return {(s < 0), 16'(s)};
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sb_vld_q  <= 1'b0;
            sb_data_q <= 16'd0;
            sb_sign_q <= 1'b0;
            for (int k = 0; k <= 2*W+1; k++) hist_q[k] <= 8'd0;
        end else if (sobel_valid_o && sobel_ready_i) begin
            sb_vld_q                <= 1'b1;
            {sb_sign_q, sb_data_q}  <= sb_result(sobel_data_o);
            hist_q[0]               <= sobel_data_o;
            for (int k = 1; k <= 2*W+1; k++) hist_q[k] <= hist_q[k-1];
        end else if (sb_vld_q && sobel_ready_o) begin
            sb_vld_q <= 1'b0;
        end
    end

    // Reference model data
    int kt [4][9] = '{'{-1, 0, 1, -2, 0, 2, -1, 0, 1},
                      '{-1, -2, -1, 0, 0, 0, 1, 2, 1},
                      '{0, 1, 0, 1, -4, 1, 0, 1, 0},
                      '{0, 0, 0, 0, 1, 0, 0, 0, 0}};
    int frame_px [NPIX];
    logic [18:0] exp_q [$];
    logic [18:0] got_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    bit rdy_rand = 1'b0;
    logic rdy_level = 1'b1;
    bit hold_pending = 1'b0;
    logic [15:0] hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic weights_t kw(input int sel);
        weights_t w;
        for (int i = 0; i < 9; i++) w[i] = 3'(kt[sel][i]);
        return w;
    endfunction

    task automatic make_pattern(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0:       frame_px[r*W+c] = r * W + c;
                    1:       frame_px[r*W+c] = (c >= 3) ? 10 : 0;
                    2:       frame_px[r*W+c] = (r == 2 && c == 2) ? 100 : 0;
                    3:       frame_px[r*W+c] = 7;
                    default: frame_px[r*W+c] = int'($urandom_range(255));
                endcase
            end
        end
    endtask

    task automatic ref_frame(input int sel, input int absm);
        int s, d;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += kt[sel][i*3+j] * frame_px[(r-1+i)*W + (c-1+j)];
                d = (absm != 0 && s < 0) ? -s : s;
                exp_q.push_back({(s < 0), (r == 1 && c == 1), (r == H-2 && c == W-2), 16'(d)});
            end
        end
    endtask

    task automatic send_frame(input int sel, input int absm, input int npix, input int vpct,
                              input int tog_at, input int tog_sel, input bit chk_sw, input int old_sel);
        bit done;
        int guard;
        kernel_sel_i = 2'(sel);
        abs_i        = absm[0];
        if (chk_sw) check("weights_before_switch", 64'(weights_o), 64'(kw(old_sel)));
        for (int p = 0; p < npix; p++) begin
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                @(negedge clk);
                if (p == tog_at) kernel_sel_i = 2'(tog_sel);
                valid_i = (int'($urandom_range(99)) < vpct);
                data_i  = 8'(frame_px[p]);
                #4;
                done = valid_i && ready_o;
                @(posedge clk);
                #1;
                guard++;
                if (!done && guard > 2000) begin
                    $display("FAIL send_timeout: pixel %0d not accepted", p);
                    $fatal(1);
                end
            end
            if (chk_sw && p == 0) check("weights_after_switch", 64'(weights_o), 64'(kw(sel)));
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_outputs(input string name, input int n, input int bound);
        int cyc = 0;
        while (got_q.size() < n && cyc < bound) begin
            @(posedge clk);
            cyc++;
        end
        repeat (4) @(posedge clk);
        check(name, 64'(got_q.size()), 64'(n));
    endtask

    task automatic compare_queues(input string name);
        logic [18:0] g;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 19'h7FFFF;
            check(name, 64'(g), 64'(exp_q[i]));
        end
    endtask

    // ready_i driver
    initial begin
        ready_i = 1'b1;
        forever begin
            @(negedge clk);
            ready_i = rdy_rand ? 1'($urandom_range(1)) : rdy_level;
        end
    end

    // Output monitor: captures handshakes, checks back-pressure hold, counts done pulses.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset_i) begin
                if (hold_pending) begin
                    check("bp_hold", 64'({valid_o, data_o}), 64'({1'b1, hold_data}));
                    hold_pending = 1'b0;
                end
                if (valid_o && ready_i) got_q.push_back({sign_o, sof_o, last_o, data_o});
                if (valid_o && !ready_i) begin
                    hold_pending = 1'b1;
                    hold_data    = data_o;
                end
                if (frame_done_o) fd_cnt++;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [1:0]       sel;
        logic             absm;
        logic [1:0]       pat;
        logic [0:8][15:0] expd;
        logic [0:8]       neg;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [18:0] want;
        vecs[0] = '{sel: 2'd3, absm: 1'b0, pat: 2'd0, neg: 9'b0,
                    expd: {16'd6, 16'd7, 16'd8, 16'd11, 16'd12, 16'd13, 16'd16, 16'd17, 16'd18}};
        vecs[1] = '{sel: 2'd0, absm: 1'b1, pat: 2'd1, neg: 9'b0,
                    expd: {16'd0, 16'd40, 16'd40, 16'd0, 16'd40, 16'd40, 16'd0, 16'd40, 16'd40}};
        vecs[2] = '{sel: 2'd0, absm: 1'b0, pat: 2'd1, neg: 9'b0,
                    expd: {16'd0, 16'd40, 16'd40, 16'd0, 16'd40, 16'd40, 16'd0, 16'd40, 16'd40}};
        vecs[3] = '{sel: 2'd2, absm: 1'b0, pat: 2'd2, neg: 9'b000010000,
                    expd: {16'd0, 16'd100, 16'd0, 16'd100, 16'hFE70, 16'd100, 16'd0, 16'd100, 16'd0}};
        vecs[4] = '{sel: 2'd1, absm: 1'b0, pat: 2'd3, neg: 9'b0,
                    expd: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};

        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i = 8'd0;
        kernel_sel_i = 2'd0;
        abs_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #4;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_weights", 64'(weights_o), 64'd0);
        check("rst_abs", 64'(abs_o), 64'd0);
        check("rst_done", 64'(frame_done_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);

        // Table-driven single frames with ready_i held high
        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            fd_cnt = 0;
            make_pattern(int'(vecs[v].pat));
            send_frame(int'(vecs[v].sel), int'(vecs[v].absm), NPIX, 100, -1, 0, 1'b0, 0);
            wait_outputs("tbl_count", 9, 300);
            for (int k = 0; k < 9; k++) begin
                want = {vecs[v].neg[k], (k == 0), (k == 8), vecs[v].expd[k]};
                check("tbl_result", (k < got_q.size()) ? 64'(got_q[k]) : 64'h7FFFF, 64'(want));
            end
            check("tbl_frame_done", 64'(fd_cnt), 64'd1);
            check("tbl_weights", 64'(weights_o), 64'(kw(int'(vecs[v].sel))));
            check("tbl_abs", 64'(abs_o), 64'(vecs[v].absm));
        end

        // Config change mid-frame, DRAIN stall, then weights switch on next frame's first pixel
        got_q.delete();
        exp_q.delete();
        make_pattern(9);
        ref_frame(0, 0);
        send_frame(0, 0, NPIX, 100, 10, 1, 1'b0, 0);
        rdy_level = 1'b0;
        ready_i   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #4;
            check("drain_ready_low", 64'({ready_o, busy_o}), 64'b01);
            check("drain_weights", 64'(weights_o), 64'(kw(0)));
            check("drain_last_held", 64'({valid_o, last_o}), 64'b11);
        end
        rdy_level = 1'b1;
        for (int c = 0; c < 50 && busy_o; c++) @(posedge clk);
        check("drain_exit", 64'(busy_o), 64'd0);
        make_pattern(3);
        ref_frame(1, 0);
        send_frame(1, 0, NPIX, 100, -1, 0, 1'b1, 0);
        wait_outputs("cfg_count", 18, 300);
        compare_queues("cfg_result");

        // Randomised handshakes over three back-to-back frames
        got_q.delete();
        exp_q.delete();
        fd_cnt   = 0;
        rdy_rand = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int sel, absm;
            sel  = int'($urandom_range(3));
            absm = int'($urandom_range(1));
            make_pattern(9);
            ref_frame(sel, absm);
            send_frame(sel, absm, NPIX, 50, -1, 0, 1'b0, 0);
        end
        wait_outputs("rnd_count", 27, 3000);
        for (int c = 0; c < 200 && busy_o; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        compare_queues("rnd_result");
        check("rnd_frame_done", 64'(fd_cnt), 64'd3);
        check("rnd_no_dup", 64'(got_q.size()), 64'd27);
        rdy_rand  = 1'b0;
        rdy_level = 1'b1;

        // Reset in the middle of a frame, then a clean frame
        make_pattern(9);
        send_frame(2, 1, 12, 100, -1, 0, 1'b0, 0);
        @(negedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_weights", 64'(weights_o), 64'd0);
        check("midrst_abs", 64'(abs_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        make_pattern(0);
        ref_frame(3, 0);
        send_frame(3, 0, NPIX, 100, -1, 0, 1'b0, 0);
        wait_outputs("midrst_count", 9, 300);
        compare_queues("midrst_result");
        check("midrst_sof_first", (got_q.size() > 0) ? 64'(got_q[0][17]) : 64'd0, 64'd1);
        check("midrst_frame_done", 64'(fd_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
